// File: rtl/lbp_pkg.sv
// Shared constants, FSM state type and neighbour bit positions for the LBP scan datapath.
package lbp_pkg;
  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int AW    = 14;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_e;

  localparam int NB_TL = 0;
  localparam int NB_T  = 1;
  localparam int NB_TR = 2;
  localparam int NB_L  = 3;
  localparam int NB_R  = 4;
  localparam int NB_BL = 5;
  localparam int NB_B  = 6;
  localparam int NB_BR = 7;
endpackage

// File: rtl/lbp_core.sv
// Combinational 3x3 local binary pattern; win index is row*3+col, centre at index 4.
module lbp_core import lbp_pkg::*; (
  input  logic [8:0][7:0] win,
  output logic [7:0]      code
);
  always_comb begin
    code        = '0;
    // neighbour >= centre sets the bit, so a flat patch codes as 0xFF
    code[NB_TL] = win[0] >= win[4];
    code[NB_T]  = win[1] >= win[4];
    code[NB_TR] = win[2] >= win[4];
    code[NB_L]  = win[3] >= win[4];
    code[NB_R]  = win[5] >= win[4];
    code[NB_BL] = win[6] >= win[4];
    code[NB_B]  = win[7] >= win[4];
    code[NB_BR] = win[8] >= win[4];
  end
endmodule

// File: rtl/lbp_scan_ctrl.sv
// Column-wise 3x3 window scanner over a gray image; emits one LBP code per interior pixel.
module lbp_scan_ctrl import lbp_pkg::*; #(
  parameter int IMG_W = lbp_pkg::IMG_W,
  parameter int IMG_H = lbp_pkg::IMG_H,
  parameter int AW    = lbp_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [7:0]    gray_data,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          finish
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  state_e               state_q, state_d;
  logic                 gray_req_q, gray_req_d;
  logic [AW-1:0]        gray_addr_q, gray_addr_d;
  logic [RW-1:0]        row_q, row_d;
  logic [CW-1:0]        col_q, col_d;
  logic [1:0]           ph_q, ph_d;
  logic [1:0][7:0]      colbuf_q, colbuf_d;
  logic [2:0][2:0][7:0] win_q, win_d, win_n;   // [col][row]
  logic                 lbp_valid_q, lbp_valid_d;
  logic [AW-1:0]        lbp_addr_q, lbp_addr_d;
  logic [7:0]           lbp_data_q, lbp_data_d;
  logic                 finish_q, finish_d;
  logic [8:0][7:0]      core_win;
  logic [7:0]           core_code;

  lbp_core u_core (.win(core_win), .code(core_code));

  // window as it will look after this cycle's third read lands in the right column
  always_comb begin
    win_n       = '0;
    win_n[0]    = win_q[1];
    win_n[1]    = win_q[2];
    win_n[2][0] = colbuf_q[0];
    win_n[2][1] = colbuf_q[1];
    win_n[2][2] = gray_data;
    core_win    = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        core_win[r*3+c] = win_n[c][r];
  end

  always_comb begin
    state_d     = state_q;
    gray_req_d  = 1'b0;
    gray_addr_d = gray_addr_q;
    row_d       = row_q;
    col_d       = col_q;
    ph_d        = ph_q;
    colbuf_d    = colbuf_q;
    win_d       = win_q;
    lbp_valid_d = 1'b0;
    lbp_addr_d  = lbp_addr_q;
    lbp_data_d  = lbp_data_q;
    finish_d    = finish_q;
    case (state_q)
      IDLE: begin
        if (gray_ready) begin
          state_d     = FETCH;
          gray_req_d  = 1'b1;
          row_d       = RW'(1);
          col_d       = '0;
          ph_d        = '0;
          gray_addr_d = '0;
        end
      end
      FETCH: begin
        gray_req_d = gray_ready;
        if (gray_req_q) begin
          if (ph_q != 2'd2) begin
            ph_d                = ph_q + 2'd1;
            colbuf_d[ph_q[0]]   = gray_data;
          end else begin
            ph_d  = '0;
            win_d = win_n;
            if (col_q >= CW'(2)) begin
              lbp_valid_d = 1'b1;
              lbp_addr_d  = AW'(int'(row_q) * IMG_W + int'(col_q) - 1);
              lbp_data_d  = core_code;
            end
            if (col_q == CW'(IMG_W-1)) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
            if (col_q == CW'(IMG_W-1) && row_q == RW'(IMG_H-2)) begin
              state_d    = DONE;
              gray_req_d = 1'b0;
            end
          end
          // rows above/below centre are selected by the read phase
          if (state_d == FETCH)
            gray_addr_d = AW'((int'(row_d) + int'(ph_d) - 1) * IMG_W + int'(col_d));
        end
      end
      DONE:    finish_d = 1'b1;
      default: state_d  = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      row_q       <= '0;
      col_q       <= '0;
      ph_q        <= '0;
      colbuf_q    <= '0;
      win_q       <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gray_req_q  <= gray_req_d;
      gray_addr_q <= gray_addr_d;
      row_q       <= row_d;
      col_q       <= col_d;
      ph_q        <= ph_d;
      colbuf_q    <= colbuf_d;
      win_q       <= win_d;
      lbp_valid_q <= lbp_valid_d;
      lbp_addr_q  <= lbp_addr_d;
      lbp_data_q  <= lbp_data_d;
      finish_q    <= finish_d;
    end
  end

  assign gray_req  = gray_req_q;
  assign gray_addr = gray_addr_q;
  assign lbp_valid = lbp_valid_q;
  assign lbp_addr  = lbp_addr_q;
  assign lbp_data  = lbp_data_q;
  assign finish    = finish_q;
endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Bench: full-size random frame for start/timing, plus a 16x16 instance for pattern, stall and reset cases.
module tb_lbp_scan_ctrl;
  localparam int W0 = 128, H0 = 128, A0 = 14;
  localparam int W1 = 16,  H1 = 16,  A1 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst0, rdy0, req0, vld0, fin0;
  logic [A0-1:0] addr0, laddr0;
  logic [7:0]    gd0, ld0;
  logic          rst1, rdy1, req1, vld1, fin1;
  logic [A1-1:0] addr1, laddr1;
  logic [7:0]    gd1, ld1;

  logic [7:0] img0[W0*H0];
  logic [7:0] res0[W0*H0];
  logic [7:0] img1[W1*H1];
  logic [7:0] res1[W1*H1];

  int n_chk = 0, n_pass = 0;
  int cyc, pulses0, pulses1, last0, last1;

  assign gd0 = img0[addr0];
  assign gd1 = img1[addr1];

  lbp_scan_ctrl u_dut0 (
    .clk(clk), .reset(rst0), .gray_ready(rdy0), .gray_req(req0), .gray_addr(addr0),
    .gray_data(gd0), .lbp_valid(vld0), .lbp_addr(laddr0), .lbp_data(ld0), .finish(fin0));

  lbp_scan_ctrl #(.IMG_W(W1), .IMG_H(H1), .AW(A1)) u_dut1 (
    .clk(clk), .reset(rst1), .gray_ready(rdy1), .gray_req(req1), .gray_addr(addr1),
    .gray_data(gd1), .lbp_valid(vld1), .lbp_addr(laddr1), .lbp_data(ld1), .finish(fin1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // advance to the next falling edge and capture any result-memory write
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (vld0) begin res0[laddr0] = ld0; pulses0++; last0 = int'(laddr0); end
    if (vld1) begin res1[laddr1] = ld1; pulses1++; last1 = int'(laddr1); end
  endtask

  function automatic logic [7:0] px(input int which, input int r, input int c);
    return (which == 0) ? img0[r*W0+c] : img1[r*W1+c];
  endfunction

  function automatic logic [7:0] ref_lbp(input int which, input int r, input int c);
    int dr[8];
    int dc[8];
    logic [7:0] code;
    dr = '{-1, -1, -1, 0, 0, 1, 1, 1};
    dc = '{-1,  0,  1, -1, 1, -1, 0, 1};
    code = '0;
    for (int k = 0; k < 8; k++)
      code[k] = px(which, r + dr[k], c + dc[k]) >= px(which, r, c);
    return code;
  endfunction

  task automatic mem_check(input int which, input string tag);
    int w, h, nbad, first;
    logic [7:0] exp, got;
    w = (which == 0) ? W0 : W1;
    h = (which == 0) ? H0 : H1;
    nbad = 0; first = -1;
    for (int a = 0; a < w*h; a++) begin
      exp = (a/w > 0 && a/w < h-1 && a%w > 0 && a%w < w-1) ? ref_lbp(which, a/w, a%w) : 8'h00;
      got = (which == 0) ? res0[a] : res1[a];
      if (got !== exp) begin nbad++; if (first < 0) first = a; end
    end
    chk($sformatf("%s_bad_entries(first@%0d)", tag, first), nbad, 0);
  endtask

  task automatic clear1();
    for (int a = 0; a < W1*H1; a++) res1[a] = 8'h00;
    pulses1 = 0; last1 = -1;
  endtask

  // mode 0: random low-range pixels (many ties), 1: flat 0x55, 2: 100 with a dip at (5,5)
  task automatic fill1(input int mode);
    for (int a = 0; a < W1*H1; a++)
      case (mode)
        0:       img1[a] = 8'($urandom_range(0, 3));
        1:       img1[a] = 8'h55;
        default: img1[a] = 8'd100;
      endcase
    if (mode == 2) img1[5*W1+5] = 8'd50;
  endtask

  task automatic frame1(input string tag, input int stall_at, input int rst_at, input int exp_fin);
    logic [A1-1:0] held;
    bit did_rst;
    int fin_cyc;
    rst1 = 1'b1; rdy1 = 1'b0;
    tick(); tick();
    rst1 = 1'b0;
    clear1();
    rdy1 = 1'b1; cyc = 0; fin_cyc = 0; did_rst = 1'b0; held = '0;
    while (fin_cyc == 0 && cyc < 3000) begin
      tick();
      if (cyc == 1) chk({tag, "_first_req"}, {req1, addr1}, {1'b1, 8'd0});
      if (fin1) fin_cyc = cyc;
      if (stall_at != 0) begin
        if (cyc == stall_at) rdy1 = 1'b0;
        if (cyc == stall_at + 1) held = addr1;
        if (cyc > stall_at && cyc <= stall_at + 5) begin
          chk({tag, "_stall_req"}, req1, 1'b0);
          chk({tag, "_stall_addr_held"}, addr1, held);
        end
        if (cyc == stall_at + 5) rdy1 = 1'b1;
        if (cyc == stall_at + 6) chk({tag, "_resume"}, {req1, addr1}, {1'b1, held});
      end
      if (rst_at != 0 && !did_rst && cyc == rst_at) begin
        did_rst = 1'b1;
        rst1 = 1'b1;
        tick();
        chk({tag, "_midrst_outs"}, {req1, addr1, vld1, laddr1, ld1, fin1}, 0);
        rst1 = 1'b0;
        clear1();
        cyc = 0;
      end
    end
    chk({tag, "_finish_cyc"}, fin_cyc, exp_fin);
    chk({tag, "_pulses"}, pulses1, (W1-2)*(H1-2));
    mem_check(1, tag);
    tick();
    chk({tag, "_finish_held"}, {fin1, req1}, 2'b10);
  endtask

  initial begin
    int col, ph;
    bit seen;
    rst0 = 1'b1; rst1 = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0;
    pulses0 = 0; pulses1 = 0; last0 = -1; last1 = -1; cyc = 0;
    for (int a = 0; a < W0*H0; a++) begin
      img0[a] = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
      res0[a] = 8'h00;
    end
    fill1(0); clear1();
    tick(); tick();
    chk("rst_outs0", {req0, addr0, vld0, laddr0, ld0, fin0}, 0);
    chk("rst_outs1", {req1, addr1, vld1, laddr1, ld1, fin1}, 0);
    rst0 = 1'b0; rst1 = 1'b0;
    tick();
    chk("idle_no_req0", {req0, fin0}, 0);

    // full-size frame: start addresses, first write, pulse count and finish timing
    rdy0 = 1'b1; cyc = 0; pulses0 = 0; seen = 1'b0;
    while (!fin0 && cyc < 60000) begin
      tick();
      if (cyc <= 9) begin
        col = (cyc - 1) / 3; ph = (cyc - 1) % 3;
        chk($sformatf("start_addr%0d", cyc), {req0, addr0}, {1'b1, 14'(ph*W0 + col)});
      end
      if (vld0 && !seen) begin
        seen = 1'b1;
        chk("first_vld_cyc", cyc, 10);
        chk("first_vld_addr", laddr0, 129);
      end
    end
    chk("finish_cyc0", cyc, (H0-2)*W0*3 + 2);
    chk("pulses0", pulses0, (W0-2)*(H0-2));
    chk("last_addr0", last0, (H0-2)*W0 + W0-2);
    mem_check(0, "frame0");

    fill1(1);
    frame1("flat", 0, 0, (H1-2)*W1*3 + 2);
    chk("flat_last_addr", last1, (H1-2)*W1 + W1-2);
    chk("flat_center", res1[7*W1+7], 8'hFF);

    fill1(2);
    frame1("dip", 0, 0, (H1-2)*W1*3 + 2);
    chk("dip_4_4", res1[4*W1+4], 8'h7F);
    chk("dip_4_5", res1[4*W1+5], 8'hBF);
    chk("dip_6_6", res1[6*W1+6], 8'hFE);
    chk("dip_5_5", res1[5*W1+5], 8'hFF);

    fill1(0);
    frame1("stall", 300, 0, (H1-2)*W1*3 + 2 + 5);
    fill1(0);
    frame1("stall_b", 301, 0, (H1-2)*W1*3 + 2 + 5);
    fill1(0);
    frame1("midrst", 0, 350, (H1-2)*W1*3 + 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
